// File: rtl/vlib_mac_pkg.sv
// Shared width and saturation helpers for the multi-lane MAC datapath.
package vlib_mac_pkg;

    // Widest accumulator the saturation helpers can describe.
    localparam int MAX_ACC_W = 64;

    // Full-precision width of one signed a x b product.
    function automatic int PROD_W(input int a, input int b);
        return a + b;
    endfunction

    // Width that holds the sum of 'lanes' full-precision products.
    function automatic int SUM_W(input int a, input int b, input int lanes);
        return a + b + $clog2(lanes);
    endfunction

    // Largest positive value of a signed 'width'-bit number.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Most negative value of a signed 'width'-bit number.
    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/VLIB_multiplier.sv
// Combinational signed multiplier producing the full-precision product.
module VLIB_multiplier #(
    parameter int A_W = 8,
    parameter int B_W = 8
) (
    input  logic signed [A_W-1:0]     a,
    input  logic signed [B_W-1:0]     b,
    output logic signed [A_W+B_W-1:0] p
);

    localparam int P_W = A_W + B_W;

    // Both operands are sign-extended to the product width before multiplying.
    assign p = P_W'(a) * P_W'(b);

endmodule

// File: rtl/vlib_adder_tree.sv
// Combinational signed reduction of LANES values; binary tree, odd element
// of a level is passed straight through to the next level.
module vlib_adder_tree #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 18,
    parameter int LANES = 4
) (
    input  logic [LANES*IN_W-1:0] in_flat,
    output logic [OUT_W-1:0]      sum
);

    localparam int LV = $clog2(LANES);

    // Number of live partial sums at a given tree level.
    function automatic int lanes_at(input int level);
        int c;
        c = LANES;
        for (int k = 0; k < level; k++) c = (c + 1) / 2;
        return c;
    endfunction

    logic signed [OUT_W-1:0] lv [LV+1][LANES];

    // Level 0: sign-extend every input to the final width so no level can overflow.
    for (genvar i = 0; i < LANES; i++) begin : g_leaf
        assign lv[0][i] = OUT_W'($signed(in_flat[i*IN_W +: IN_W]));
    end

    for (genvar k = 0; k < LV; k++) begin : g_level
        localparam int N = lanes_at(k);
        for (genvar i = 0; i < N / 2; i++) begin : g_pair
            assign lv[k+1][i] = lv[k][2*i] + lv[k][2*i+1];
        end
        if (N % 2 == 1) begin : g_odd
            assign lv[k+1][N/2] = lv[k][N-1];
        end
        for (genvar i = (N + 1) / 2; i < LANES; i++) begin : g_pad
            assign lv[k+1][i] = '0;
        end
    end

    assign sum = lv[LV][0];

endmodule

// File: rtl/vlib_mac_lanes.sv
// Pipelined multi-lane signed multiply-accumulate. Products of each beat are
// summed and accumulated over a FIRST..LAST vector; one result per vector
// leaves on a valid/ready output, optionally saturated.
module vlib_mac_lanes
    import vlib_mac_pkg::*;
#(
    parameter int BITWIDTH_A = 8,
    parameter int BITWIDTH_B = BITWIDTH_A,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int PIPE       = 1,
    parameter int SATURATE   = 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic [LANES*BITWIDTH_A-1:0]   IN_A,
    input  logic [LANES*BITWIDTH_B-1:0]   IN_B,
    input  logic                          IN_FIRST,
    input  logic                          IN_LAST,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [ACC_WIDTH-1:0]          OUT_RES,
    output logic                          OUT_OVF
);

    localparam int PW  = PROD_W(BITWIDTH_A, BITWIDTH_B);
    localparam int SW  = SUM_W(BITWIDTH_A, BITWIDTH_B, LANES);
    localparam int AW1 = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    if (LANES < 1 || ACC_WIDTH < SW || ACC_WIDTH > MAX_ACC_W || (PIPE != 0 && PIPE != 1)) begin : g_cfg_err
        $error("vlib_mac_lanes: illegal parameter combination");
    end

    // One enable moves every stage together; a stalled result freezes the pipe.
    logic en;
    logic out_valid_q, out_valid_d;
    assign en       = !out_valid_q | OUT_READY;
    assign IN_READY = en;

    logic [LANES*PW-1:0] prod_flat;
    for (genvar l = 0; l < LANES; l++) begin : g_mul
        VLIB_multiplier #(.A_W(BITWIDTH_A), .B_W(BITWIDTH_B)) u_mul (
            .a (IN_A[l*BITWIDTH_A +: BITWIDTH_A]),
            .b (IN_B[l*BITWIDTH_B +: BITWIDTH_B]),
            .p (prod_flat[l*PW +: PW])
        );
    end

    logic                a_valid, a_first, a_last;
    logic [LANES*PW-1:0] a_prod;

    if (PIPE == 1) begin : g_pipe
        logic                m_valid_q, m_valid_d, m_first_q, m_first_d, m_last_q, m_last_d;
        logic [LANES*PW-1:0] m_prod_q, m_prod_d;

        // Stage M next state: take the incoming beat whenever the pipe advances.
        always_comb begin
            // NOTE: every _d starts from its held value so no path leaves it unassigned (no latch).
            m_valid_d = m_valid_q;
            m_first_d = m_first_q;
            m_last_d  = m_last_q;
            m_prod_d  = m_prod_q;
            if (en) begin
                m_valid_d = IN_VALID;
                m_first_d = IN_FIRST;
                m_last_d  = IN_LAST;
                m_prod_d  = prod_flat;
            end
        end

        // Stage M registers; reset drops any beat in flight.
        always_ff @(posedge CLK or negedge RST_N) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (!RST_N) begin
                m_valid_q <= 1'b0;
                m_first_q <= 1'b0;
                m_last_q  <= 1'b0;
                m_prod_q  <= '0;
            end else begin
                m_valid_q <= m_valid_d;
                m_first_q <= m_first_d;
                m_last_q  <= m_last_d;
                m_prod_q  <= m_prod_d;
            end
        end

        assign a_valid = m_valid_q;
        assign a_first = m_first_q;
        assign a_last  = m_last_q;
        assign a_prod  = m_prod_q;
    end else begin : g_nopipe
        assign a_valid = IN_VALID;
        assign a_first = IN_FIRST;
        assign a_last  = IN_LAST;
        assign a_prod  = prod_flat;
    end

    logic [SW-1:0] sum;
    vlib_adder_tree #(.IN_W(PW), .OUT_W(SW), .LANES(LANES)) u_tree (
        .in_flat (a_prod),
        .sum     (sum)
    );

    logic [ACC_WIDTH-1:0] acc_q, acc_d, out_res_q, out_res_d, result;
    logic                 ovf_q, ovf_d, out_ovf_q, out_ovf_d, ovf, sticky;
    logic signed [ACC_WIDTH:0] sum_ext, base, t;

    // Stage A: one extra bit exposes overflow; LAST hands the result out and
    // clears the accumulator so the next beat starts from zero.
    always_comb begin
        sum_ext = AW1'($signed(sum));
        base    = a_first ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
        t       = base + sum_ext;
        ovf     = t[ACC_WIDTH] ^ t[ACC_WIDTH-1];
        result  = t[ACC_WIDTH-1:0];
        if (ovf && SATURATE != 0) result = t[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        sticky  = (a_first ? 1'b0 : ovf_q) | ovf;

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_res_d   = out_res_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = a_valid & a_last;
            if (a_valid) begin
                if (a_last) begin
                    out_res_d = result;
                    out_ovf_d = sticky;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                end else begin
                    acc_d = result;
                    ovf_d = sticky;
                end
            end
        end
    end

    // Accumulator and output registers; reset discards any partial vector.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_res_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_res_q   <= out_res_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_RES   = out_res_q;
    assign OUT_OVF   = out_ovf_q;

endmodule

// File: tb/tb_vlib_mac_lanes.sv
// Bench for vlib_mac_lanes: three configurations (32-bit saturating, 18-bit
// saturating, 18-bit wrapping) share one stimulus stream. A vector-level model
// predicts each result; a negedge process scoreboards every handshake.
module tb_vlib_mac_lanes;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_first, in_last, out_ready;
    logic [31:0] in_a, in_b;

    logic        rdy0, rdy1, rdy2, v0, v1, v2, ovf0, ovf1, ovf2;
    logic [31:0] res0;
    logic [17:0] res1, res2;

    always #5 clk = ~clk;

    vlib_mac_lanes u_dut0 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy0),
        .IN_A(in_a), .IN_B(in_b), .IN_FIRST(in_first), .IN_LAST(in_last),
        .OUT_VALID(v0), .OUT_READY(out_ready), .OUT_RES(res0), .OUT_OVF(ovf0));

    vlib_mac_lanes #(.ACC_WIDTH(18), .SATURATE(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy1),
        .IN_A(in_a), .IN_B(in_b), .IN_FIRST(in_first), .IN_LAST(in_last),
        .OUT_VALID(v1), .OUT_READY(out_ready), .OUT_RES(res1), .OUT_OVF(ovf1));

    vlib_mac_lanes #(.ACC_WIDTH(18), .SATURATE(0)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy2),
        .IN_A(in_a), .IN_B(in_b), .IN_FIRST(in_first), .IN_LAST(in_last),
        .OUT_VALID(v2), .OUT_READY(out_ready), .OUT_RES(res2), .OUT_OVF(ovf2));

    logic   dv[3], drdy[3], dovf[3];
    longint dres[3];
    assign dv[0] = v0;   assign dv[1] = v1;   assign dv[2] = v2;
    assign drdy[0] = rdy0; assign drdy[1] = rdy1; assign drdy[2] = rdy2;
    assign dovf[0] = ovf0; assign dovf[1] = ovf1; assign dovf[2] = ovf2;
    assign dres[0] = longint'($signed(res0));
    assign dres[1] = longint'($signed(res1));
    assign dres[2] = longint'($signed(res2));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- vector-level model ----------------
    longint macc[3];
    bit     mst[3];
    longint fifo_res[3][64];
    bit     fifo_ovf[3][64];
    int     wr_p[3], rd_p[3];
    bit     hold_v[3], hold_o[3];
    longint hold_r[3];

    function automatic int w_of(input int d);
        return (d == 0) ? 32 : 18;
    endfunction

    function automatic longint wrap_to(input longint t, input int w);
        longint s;
        s = t <<< (64 - w);
        return s >>> (64 - w);
    endfunction

    task automatic model_beat(input int d);
        logic signed [7:0] av, bv;
        longint dot, t, r, mx, mn;
        bit o;
        dot = 0;
        for (int l = 0; l < 4; l++) begin
            av = in_a[8*l +: 8];
            bv = in_b[8*l +: 8];
            dot += longint'(av) * longint'(bv);
        end
        if (in_first) begin
            macc[d] = 0;
            mst[d]  = 1'b0;
        end
        mx = (longint'(1) <<< (w_of(d) - 1)) - 1;
        mn = -(longint'(1) <<< (w_of(d) - 1));
        t  = macc[d] + dot;
        o  = (t > mx) || (t < mn);
        r  = t;
        if (o) r = (d != 2) ? ((t > mx) ? mx : mn) : wrap_to(t, w_of(d));
        mst[d] = mst[d] | o;
        if (in_last) begin
            fifo_res[d][wr_p[d] % 64] = r;
            fifo_ovf[d][wr_p[d] % 64] = mst[d];
            wr_p[d]++;
            macc[d] = 0;
            mst[d]  = 1'b0;
        end else begin
            macc[d] = r;
        end
    endtask

    // Scoreboard: decisions sampled at negedge apply to the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                macc[d]   = 0;
                mst[d]    = 1'b0;
                rd_p[d]   = wr_p[d];
                hold_v[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("in_ready%0d", d), longint'(drdy[d]), longint'(!dv[d] | out_ready));
                if (hold_v[d]) begin
                    check($sformatf("stall_valid%0d", d), longint'(dv[d]), 1);
                    check($sformatf("stall_res%0d", d), dres[d], hold_r[d]);
                    check($sformatf("stall_ovf%0d", d), longint'(dovf[d]), longint'(hold_o[d]));
                end
                if (dv[d] && out_ready) begin
                    if (wr_p[d] == rd_p[d]) begin
                        check($sformatf("spurious_out%0d", d), 1, 0);
                    end else begin
                        check($sformatf("sb_res%0d", d), dres[d], fifo_res[d][rd_p[d] % 64]);
                        check($sformatf("sb_ovf%0d", d), longint'(dovf[d]), longint'(fifo_ovf[d][rd_p[d] % 64]));
                        rd_p[d]++;
                    end
                end
                hold_v[d] = dv[d] & !out_ready;
                hold_r[d] = dres[d];
                hold_o[d] = dovf[d];
                if (in_valid && drdy[d]) model_beat(d);
            end
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Presents one beat and returns just after the rising edge that accepted it.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l);
        int n;
        in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) check("send_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input int d, input longint res, input bit ovf);
        check({name, "_valid"}, longint'(dv[d]), 1);
        check({name, "_res"}, dres[d], res);
        check({name, "_ovf"}, longint'(dovf[d]), longint'(ovf));
    endtask

    task automatic expect_out(input string name, input int d, input longint res, input bit ovf);
        int n;
        n = 0;
        @(negedge clk);
        while (!dv[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_now(name, d, res, ovf);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int d = 0; d < 3; d++) begin
            wr_p[d] = 0; rd_p[d] = 0; macc[d] = 0; mst[d] = 1'b0; hold_v[d] = 1'b0;
        end
        rst_n = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
        idle();
        repeat (2) step();
        check("rst_valid", longint'(v0), 0);
        check("rst_res", longint'(res0), 0);
        check("rst_ovf", longint'(ovf0), 0);
        check("rst_res18", longint'(res1), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", longint'(rdy0), 1);
        step();

        // Single-beat vector: 1*5+2*6+3*7+4*8 = 70, two edges after acceptance.
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1);
        idle();
        @(negedge clk); check("lat_edge1_valid", longint'(v0), 0);
        @(negedge clk); check_now("single70", 0, 70, 1'b0);
        @(negedge clk); check("lat_consumed", longint'(v0), 0);
        step();

        // Three beats of 4*(-128*127), then a single-beat vector with no bubble.
        send_beat(pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 1'b1, 1'b0);
        send_beat(pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 1'b0, 1'b0);
        send_beat(pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 1'b0, 1'b1);
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1);
        idle();
        expect_out("vec3", 0, -195072, 1'b0);
        @(negedge clk); check_now("b2b70", 0, 70, 1'b0);
        step();

        // Two beats of 4*(-128*-128)=65536 overflow an 18-bit accumulator.
        send_beat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 1'b1, 1'b0);
        send_beat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 1'b0, 1'b1);
        idle();
        expect_out("sat18", 1, 131071, 1'b1);
        check_now("wrap18", 2, -131072, 1'b1);
        check_now("wide32", 0, 131072, 1'b0);
        step();
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1);
        idle();
        expect_out("sat18_next", 1, 70, 1'b0);
        step();

        // Implicit FIRST after a completed vector: 10 + 4 = 14.
        send_beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b0, 1'b0);
        send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0, 1'b1);
        idle();
        expect_out("implicit_first", 0, 14, 1'b0);
        step();

        // FIRST inside an open vector discards the partial: 36 dropped, 4 + 6 = 10.
        send_beat(pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 1'b1, 1'b0);
        send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1, 1'b0);
        send_beat(pack4(2, 0, 0, 0), pack4(3, 0, 0, 0), 1'b0, 1'b1);
        idle();
        expect_out("first_restart", 0, 10, 1'b0);
        step();

        // Backpressure: result held for 5 cycles, input blocked, then released.
        out_ready = 1'b0;
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1);
        idle();
        expect_out("stall_out", 0, 70, 1'b0);
        step();
        in_a = pack4(2, 2, 2, 2); in_b = pack4(3, 3, 3, 3);
        in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_in_ready", longint'(rdy0), 0);
            check("stall_hold_res", dres[0], 70);
            step();
        end
        out_ready = 1'b1;
        send_beat(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 1'b1, 1'b1);
        idle();
        expect_out("stall_next", 0, 24, 1'b0);
        step();

        // Random valid/ready/framing; the scoreboard checks every result.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = $urandom;
            in_b      = $urandom;
            in_first  = ($urandom_range(0, 3) == 0);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        out_ready = 1'b1;
        repeat (6) step();
        for (int d = 0; d < 3; d++) check($sformatf("drain_empty%0d", d), longint'(wr_p[d] - rd_p[d]), 0);

        // Reset with a result pending clears the outputs at once.
        out_ready = 1'b0;
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 1'b1);
        idle();
        expect_out("pre_rst", 0, 70, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", longint'(v0), 0);
        check("rst_async_res", longint'(res0), 0);
        check("rst_async_ovf", longint'(ovf0), 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Reset after 2 of 4 beats (400 each); the next vector yields only 8 + 8.
        send_beat(pack4(10, 10, 10, 10), pack4(10, 10, 10, 10), 1'b1, 1'b0);
        send_beat(pack4(10, 10, 10, 10), pack4(10, 10, 10, 10), 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", longint'(v0), 0);
        step();
        rst_n = 1'b1;
        step();
        send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0, 1'b0);
        send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0, 1'b1);
        idle();
        expect_out("post_rst", 0, 16, 1'b0);
        repeat (4) step();
        for (int d = 0; d < 3; d++) check($sformatf("final_empty%0d", d), longint'(wr_p[d] - rd_p[d]), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
